signal_monitor: RTL and testbench

SIGNAL_MONITOR -- requirements
Module: signal_monitor

---
 rtl/sigmon_pkg.sv | 39 +++
 rtl/sigmon_event_counter.sv | 21 ++
 rtl/signal_monitor.sv | 88 ++++++++
 tb/tb_signal_monitor.sv | 117 +++++++++++
 4 files changed

// File: rtl/sigmon_pkg.sv
// Shared types and constants for signal_monitor.
// Optional feature macro: SIGMON_COUNT_SATURATE_EN (event counter saturates at 15 instead of wrapping).
package sigmon_pkg;

    localparam int DATA_W = 4;
    localparam int LED_W  = 3;

    typedef enum logic [1:0] {
        MODE_COMPARE = 2'b00,
        MODE_ADD     = 2'b01,
        MODE_COUNT   = 2'b10,
        MODE_LOGIC   = 2'b11
    } mode_t;

    localparam logic [DATA_W-1:0] COUNT_MAX = '1;

    // Next event-counter value. The counter register and the top-level result
    // mux both use this, so the output always shows the value being loaded.
    function automatic logic [DATA_W-1:0] count_step(
        input logic [DATA_W-1:0] count,
        input logic              start,
        input logic              inc
    );
        logic [DATA_W-1:0] nxt;
        if (start) begin
            nxt = {{(DATA_W-1){1'b0}}, inc};
        end else if (inc) begin
`ifdef SIGMON_COUNT_SATURATE_EN
            nxt = (count == COUNT_MAX) ? COUNT_MAX : count + 1'b1;
`else
            nxt = count + 1'b1;
`endif
        end else begin
            nxt = count;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sigmon_event_counter.sv
// Event counter: loads on start, increments on inc, otherwise holds.
// Wrap vs. saturate at 15 is selected by SIGMON_COUNT_SATURATE_EN.
module sigmon_event_counter
    import sigmon_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              inc,
    output logic [DATA_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_step(count, start, inc);
        end
    end

endmodule

// File: rtl/signal_monitor.sv
// Mode-selectable monitor of two 4-bit operands with registered flags and result.
// Optional feature macro: SIGMON_COUNT_SATURATE_EN (see sigmon_pkg).
module signal_monitor
    import sigmon_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] signal_a,
    input  logic [DATA_W-1:0] signal_b,
    input  logic [1:0]        mode_select,
    output logic [LED_W-1:0]  status_leds,
    output logic [DATA_W-1:0] control_out
);

    mode_t             mode;
    mode_t             prev_mode;
    logic              a_gt_b;
    logic              a_eq_b;
    logic              a_lt_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] xor_ab;
    logic              cnt_start;
    logic              cnt_inc;
    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_next;
    logic [LED_W-1:0]  leds_d;
    logic [DATA_W-1:0] out_d;

    assign mode   = mode_t'(mode_select);
    assign a_gt_b = signal_a > signal_b;
    assign a_eq_b = signal_a == signal_b;
    assign a_lt_b = signal_a < signal_b;
    assign sum    = {1'b0, signal_a} + {1'b0, signal_b};
    assign xor_ab = signal_a ^ signal_b;

    // Counter only moves while in COUNT; outside it start/inc are low so it freezes.
    assign cnt_start = (mode == MODE_COUNT) && (prev_mode != MODE_COUNT);
    assign cnt_inc   = (mode == MODE_COUNT) && a_gt_b;
    assign cnt_next  = count_step(cnt_q, cnt_start, cnt_inc);

    sigmon_event_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .start (cnt_start),
        .inc   (cnt_inc),
        .count (cnt_q)
    );

    always_comb begin
        leds_d = '0;
        out_d  = '0;
        case (mode)
            MODE_COMPARE: begin
                leds_d = {a_gt_b, a_eq_b, a_lt_b};
                out_d  = a_gt_b ? signal_a : signal_b;
            end
            MODE_ADD: begin
                leds_d = {sum[DATA_W], sum[DATA_W-1:0] == '0, ^sum[DATA_W-1:0]};
                out_d  = sum[DATA_W-1:0];
            end
            MODE_COUNT: begin
                leds_d = {cnt_next == COUNT_MAX, a_gt_b, cnt_next != '0};
                out_d  = cnt_next;
            end
            MODE_LOGIC: begin
                leds_d = {|(signal_a & signal_b), ^xor_ab, signal_a == ~signal_b};
                out_d  = xor_ab;
            end
            default: begin
                leds_d = '0;
                out_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            status_leds <= '0;
            control_out <= '0;
            prev_mode   <= MODE_COMPARE;
        end else begin
            status_leds <= leds_d;
            control_out <= out_d;
            prev_mode   <= mode;
        end
    end

endmodule

// File: tb/tb_signal_monitor.sv
// Directed self-checking bench for signal_monitor; expected values are hand-computed.
// Honours SIGMON_COUNT_SATURATE_EN for the counter overflow expectations.
module tb_signal_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] signal_a;
    logic [3:0] signal_b;
    logic [1:0] mode_select;
    logic [2:0] status_leds;
    logic [3:0] control_out;

    int total = 0;
    int bad   = 0;

    signal_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .signal_a    (signal_a),
        .signal_b    (signal_b),
        .mode_select (mode_select),
        .status_leds (status_leds),
        .control_out (control_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one set of inputs, clock once, then settle past the edge.
    task automatic step(input logic rst, input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        reset       = rst;
        mode_select = m;
        signal_a    = a;
        signal_b    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] leds, input logic [3:0] out);
        check_eq({tag, "_leds"}, {29'd0, status_leds}, {29'd0, leds});
        check_eq({tag, "_out"},  {28'd0, control_out}, {28'd0, out});
    endtask

    initial begin
        logic [3:0] exp_cnt;

        // Reset with arbitrary inputs for two edges.
        step(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        step(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        expect_out("reset", 3'b000, 4'h0);

        // COMPARE
        step(1'b1, 2'b00, 4'd7, 4'd3);   expect_out("cmp_gt", 3'b100, 4'd7);
        step(1'b1, 2'b00, 4'd5, 4'd5);   expect_out("cmp_eq", 3'b010, 4'd5);
        step(1'b1, 2'b00, 4'd2, 4'd9);   expect_out("cmp_lt", 3'b001, 4'd9);

        // ADD
        step(1'b1, 2'b01, 4'd12, 4'd5);  expect_out("add_carry", 3'b101, 4'd1);
        step(1'b1, 2'b01, 4'd3, 4'd9);   expect_out("add_plain", 3'b000, 4'd12);
        step(1'b1, 2'b01, 4'd0, 4'd0);   expect_out("add_zero", 3'b010, 4'd0);

        // LOGIC
        step(1'b1, 2'b11, 4'd10, 4'd6);  expect_out("logic_and", 3'b100, 4'b1100);
        // a^b = 1111 has even parity, a == ~b
        step(1'b1, 2'b11, 4'd5, 4'd10);  expect_out("logic_inv", 3'b001, 4'b1111);
        step(1'b1, 2'b11, 4'd15, 4'd15); expect_out("logic_same", 3'b100, 4'b0000);

        // COUNT entry and run
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 2'b10, 4'd10, 4'd6);
            expect_out($sformatf("cnt_run%0d", i), 3'b011, 4'(i));
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'b10, 4'd10, 4'd12);
            expect_out($sformatf("cnt_hold%0d", i), 3'b001, 4'd8);
        end

        // Leave COUNT, then overflow run from a fresh entry
        step(1'b1, 2'b00, 4'd9, 4'd2);   expect_out("cmp_between", 3'b100, 4'd9);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 2'b10, 4'd9, 4'd2);
`ifdef SIGMON_COUNT_SATURATE_EN
            exp_cnt = (i >= 15) ? 4'd15 : 4'(i);
`else
            exp_cnt = 4'(i % 16);
`endif
            expect_out($sformatf("cnt_ovf%0d", i),
                       {exp_cnt == 4'd15, 1'b1, exp_cnt != 4'd0}, exp_cnt);
        end

        // Switch away and back restarts at 1
        step(1'b1, 2'b00, 4'd9, 4'd2);   expect_out("cmp_leave", 3'b100, 4'd9);
        step(1'b1, 2'b10, 4'd9, 4'd2);   expect_out("cnt_restart", 3'b011, 4'd1);
        step(1'b1, 2'b10, 4'd9, 4'd2);   expect_out("cnt_restart2", 3'b011, 4'd2);

        // Entry with a<=b loads zero
        step(1'b1, 2'b01, 4'd1, 4'd1);   expect_out("add_two", 3'b001, 4'd2);
        step(1'b1, 2'b10, 4'd3, 4'd3);   expect_out("cnt_entry0", 3'b000, 4'd0);

        // Reset overrides an active count; release in COUNT is an entry
        step(1'b1, 2'b10, 4'd9, 4'd2);   expect_out("cnt_pre_rst", 3'b011, 4'd1);
        step(1'b0, 2'b10, 4'd9, 4'd2);   expect_out("rst_override", 3'b000, 4'd0);
        step(1'b1, 2'b10, 4'd9, 4'd2);   expect_out("rst_entry", 3'b011, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
